prim_draw_engine: RTL
=====================

Name: prim_draw_engine

Overview:
- Parametrised successor to the single-pixel Bresenham line engine.
- Draws either a Bresenham line or a filled axis-aligned rectangle into the frame buffer through the DDR address FIFO and write-data FIFO.
- Pixels that fall in the same 8-pixel chunk of one row are coalesced into one 2-beat masked burst, cutting FIFO traffic for horizontal spans.
- Sits between the CPU-side graphics command registers and the memory-controller FIFOs.

Parameters:
- COORD_W, 10: coordinate width in bits (row/col); minimum 4.
- ADDR_W, 31: af_addr_din width.
- COALESCE, 1: 1 merges pixels per chunk; 0 emits one burst per pixel (legacy traffic).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- LE_ready  out  1  high in IDLE only
- LE_done  out  1  one-cycle pulse after the final burst's second beat is accepted
- LE_color  in  32  pixel value {8'h0,R,G,B}
- LE_point  in  COORD_W  coordinate payload
- LE_color_valid, LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid  in  1 each  load strobes
- LE_mode  in  1  0 = line, 1 = filled rect; sampled with LE_trigger
- LE_trigger  in  1  start command
- LE_frame_base  in  32  frame base; bits [27:22] used, sampled at trigger
- af_full, wdf_full  in  1  FIFO full flags
- af_addr_din  out  ADDR_W  burst address
- af_wr_en  out  1  address push
- wdf_din  out  128  {color,color,color,color}
- wdf_mask_din  out  16  byte mask, 1 = byte not written
- wdf_wr_en  out  1  data push

Behaviour:
- Reset: async on rst_n low. State = IDLE; coordinate, color and mode registers = 0; pending mask = all-ones. Outputs: LE_ready=1, LE_done=0, af_wr_en=0, wdf_wr_en=0, wdf_mask_din=16'hFFFF, af_addr_din=0.
- Load strobes update registers only in IDLE; they are ignored otherwise. Simultaneous strobes all load LE_point.
- LE_trigger is honoured only in IDLE and is ignored while busy.
- State machine:
  - IDLE -> SETUP on trigger.
  - SETUP (1 cycle):
    - Line mode: steep = |dy|>|dx| (a tie is not steep). Swap so the major axis runs ascending. dx, dy are absolute. err is signed (COORD_W+2 bits), initialised to dx>>1. ystep = ±1.
    - Rect mode: cmin/cmax and rmin/rmax are the sorted endpoints. Iterate row-major from (cmin, rmin).
  - PLOT: map the current point to screen (col,row); in steep mode col=minor, row=major.
    - If a chunk is pending and row or col[COORD_W-1:3] differs (or COALESCE=0 and a pixel is pending), go to SEND1 without advancing.
    - Otherwise clear the 4 mask bits of this pixel in the pending 32-bit mask. Pixel p = col[2:0] owns mask bits [31-4p -: 4].
    - If this is the last pixel, set the last flag and go to SEND1. Else advance and stay in PLOT.
    - Line advance: major+1, err -= dy; if the result is <0, minor += ystep and err += dx.
    - Rect advance: col+1, wrapping at cmax+1 to cmin with row+1.
  - SEND1: af_wr_en = wdf_wr_en = ~af_full & ~wdf_full, mask = pending[31:16]. Advance only on push.
  - SEND2: wdf_wr_en = ~wdf_full, mask = pending[15:0]. On push, clear the pending mask. If last, go to IDLE and pulse LE_done; else go to PLOT.
- Enable outputs are never asserted while the corresponding FIFO is full. wdf_mask_din = 16'hFFFF outside SEND1/SEND2.
- af_addr_din = zero-extended {fb[27:22], row, col[COORD_W-1:3], 2'b00}.
- Endpoints are inclusive. A single point (x0==x1, y0==y1) produces one burst. A zero-height rect produces one row.
- Chunk address and mask stay stable through SEND1/SEND2 regardless of backpressure duration.
- Reset mid-operation aborts immediately with no further pushes. A partial burst (SEND1 done, SEND2 not) is accepted loss; software re-issues the command.

Decomposition:
- Shared package prim_draw_pkg: state encoding (IDLE, SETUP, PLOT, SEND1, SEND2), MODE_LINE/MODE_RECT, PIX_PER_CHUNK=8, BEAT_PIX=4, and the address-pack function.
- One sub-module, prim_draw_stepper: Bresenham/rect coordinate generator with setup, advance and last outputs. It holds no FIFO logic.

Test Plan:
- Line (0,5)-(9,5), frame_base 32'h10400000, COALESCE=1 -> 2 bursts:
  - 0x80A00 with masks 0x0000/0x0000.
  - 0x80A04 with masks 0x00FF/0xFFFF.
  - Then LE_done.
- Line (3,0)-(4,4) (steep) -> 5 bursts, pixels (3,0),(3,1),(3,2),(4,3),(4,4):
  - col3 masks 0xFFF0/0xFFFF.
  - col4 masks 0xFFFF/0x0FFF.
- Rect (9,1)-(6,0) -> 4 bursts in order:
  - (r0,chunk0) masks 0xFFFF/0xFF00.
  - (r0,chunk1) masks 0x00FF/0xFFFF.
  - Then the same two for r1.
- Same horizontal line with COALESCE=0 -> 10 bursts, each with exactly 4 mask bits clear.
- Hold af_full=1 for 20 cycles at the first SEND1, then wdf_full=1 during SEND2 -> no enables while full, address/mask unchanged, burst count unchanged; LE_trigger pulsed while busy is ignored.
- Deassert rst_n in the middle of a 200-pixel line -> enables drop the same cycle, LE_ready=1. A new single-point command (7,7) -> exactly one burst with mask 0xFFFF/0xFFF0.

Source files
------------

// File: rtl/prim_draw_pkg.sv
// Shared types and helpers for the line/rectangle draw engine.
package prim_draw_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PLOT,
        S_SEND1,
        S_SEND2
    } state_t;

    localparam logic MODE_LINE = 1'b0;
    localparam logic MODE_RECT = 1'b1;

    localparam int PIX_PER_CHUNK = 8;
    localparam int BEAT_PIX      = 4;

    // Layout, LSB first: 2'b00, chunk (coord_w-3 bits), row (coord_w bits), fb[27:22].
    function automatic logic [63:0] pack_addr(input logic [5:0]  fb,
                                              input logic [31:0] row,
                                              input logic [31:0] chunk,
                                              input int          coord_w);
        logic [63:0] a;
        a = ({58'd0, fb} << (2 * coord_w - 1))
          | ({32'd0, row} << (coord_w - 1))
          | ({32'd0, chunk} << 2);
        return a;
    endfunction

endpackage

// File: rtl/prim_draw_stepper.sv
// Coordinate generator: Bresenham line or row-major rectangle walk.
module prim_draw_stepper
    import prim_draw_pkg::*;
#(
    parameter int COORD_W = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               setup,
    input  logic               advance,
    input  logic               mode,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    output logic [COORD_W-1:0] col,
    output logic [COORD_W-1:0] row,
    output logic               last
);

    localparam int EW = COORD_W + 2;

    logic [COORD_W-1:0] major_reg, minor_reg, major_end_reg, minor_end_reg, major_lo_reg;
    logic [COORD_W-1:0] dx_reg, dy_reg;
    logic signed [EW-1:0] err_reg;
    logic steep_reg, ystep_neg_reg, rect_reg;

    logic [COORD_W-1:0] dx_raw, dy_raw;
    logic [COORD_W-1:0] mj0, mn0, mj1, mn1;
    logic [COORD_W-1:0] s_mj0, s_mn0, s_mj1, s_mn1;
    logic [COORD_W-1:0] line_dx, line_dy;
    logic [COORD_W-1:0] cmin, cmax, rmin, rmax;
    logic               steep, swap;
    logic signed [EW-1:0] err_sub, err_next;

    assign dx_raw = (x1 >= x0) ? x1 - x0 : x0 - x1;
    assign dy_raw = (y1 >= y0) ? y1 - y0 : y0 - y1;
    assign steep  = dy_raw > dx_raw;

    // Fold the steep case onto a major axis, then order endpoints so it ascends.
    assign mj0  = steep ? y0 : x0;
    assign mn0  = steep ? x0 : y0;
    assign mj1  = steep ? y1 : x1;
    assign mn1  = steep ? x1 : y1;
    assign swap = mj0 > mj1;

    assign s_mj0   = swap ? mj1 : mj0;
    assign s_mn0   = swap ? mn1 : mn0;
    assign s_mj1   = swap ? mj0 : mj1;
    assign s_mn1   = swap ? mn0 : mn1;
    assign line_dx = s_mj1 - s_mj0;
    assign line_dy = (s_mn1 >= s_mn0) ? s_mn1 - s_mn0 : s_mn0 - s_mn1;

    assign cmin = (x0 < x1) ? x0 : x1;
    assign cmax = (x0 < x1) ? x1 : x0;
    assign rmin = (y0 < y1) ? y0 : y1;
    assign rmax = (y0 < y1) ? y1 : y0;

    assign err_sub  = err_reg - $signed({2'b00, dy_reg});
    assign err_next = err_sub[EW-1] ? err_sub + $signed({2'b00, dx_reg}) : err_sub;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            major_reg     <= '0;
            minor_reg     <= '0;
            major_end_reg <= '0;
            minor_end_reg <= '0;
            major_lo_reg  <= '0;
            dx_reg        <= '0;
            dy_reg        <= '0;
            err_reg       <= '0;
            steep_reg     <= 1'b0;
            ystep_neg_reg <= 1'b0;
            rect_reg      <= 1'b0;
        end else if (setup) begin
            if (mode == MODE_RECT) begin
                rect_reg      <= 1'b1;
                steep_reg     <= 1'b0;
                major_reg     <= cmin;
                minor_reg     <= rmin;
                major_end_reg <= cmax;
                minor_end_reg <= rmax;
                major_lo_reg  <= cmin;
                dx_reg        <= '0;
                dy_reg        <= '0;
                err_reg       <= '0;
                ystep_neg_reg <= 1'b0;
            end else begin
                rect_reg      <= 1'b0;
                steep_reg     <= steep;
                major_reg     <= s_mj0;
                minor_reg     <= s_mn0;
                major_end_reg <= s_mj1;
                minor_end_reg <= s_mn1;
                major_lo_reg  <= s_mj0;
                dx_reg        <= line_dx;
                dy_reg        <= line_dy;
                err_reg       <= $signed({2'b00, line_dx >> 1});
                ystep_neg_reg <= s_mn1 < s_mn0;
            end
        end else if (advance) begin
            if (rect_reg) begin
                if (major_reg == major_end_reg) begin
                    major_reg <= major_lo_reg;
                    minor_reg <= minor_reg + 1'b1;
                end else begin
                    major_reg <= major_reg + 1'b1;
                end
            end else begin
                major_reg <= major_reg + 1'b1;
                err_reg   <= err_next;
                if (err_sub[EW-1])
                    minor_reg <= ystep_neg_reg ? minor_reg - 1'b1 : minor_reg + 1'b1;
            end
        end
    end

    assign col  = steep_reg ? minor_reg : major_reg;
    assign row  = steep_reg ? major_reg : minor_reg;
    assign last = rect_reg ? (major_reg == major_end_reg && minor_reg == minor_end_reg)
                           : (major_reg == major_end_reg);

endmodule

// File: rtl/prim_draw_engine.sv
// Line / filled-rectangle rasteriser emitting 2-beat masked bursts per 8-pixel chunk.
module prim_draw_engine
    import prim_draw_pkg::*;
#(
    parameter int COORD_W  = 10,
    parameter int ADDR_W   = 31,
    parameter int COALESCE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               LE_ready,
    output logic               LE_done,
    input  logic [31:0]        LE_color,
    input  logic [COORD_W-1:0] LE_point,
    input  logic               LE_color_valid,
    input  logic               LE_x0_valid,
    input  logic               LE_y0_valid,
    input  logic               LE_x1_valid,
    input  logic               LE_y1_valid,
    input  logic               LE_mode,
    input  logic               LE_trigger,
    input  logic [31:0]        LE_frame_base,
    input  logic               af_full,
    input  logic               wdf_full,
    output logic [ADDR_W-1:0]  af_addr_din,
    output logic               af_wr_en,
    output logic [127:0]       wdf_din,
    output logic [15:0]        wdf_mask_din,
    output logic               wdf_wr_en
);

    localparam int MASK_W    = PIX_PER_CHUNK * 4;
    localparam int BEAT_BITS = BEAT_PIX * 4;

    state_t             state_reg;
    logic [COORD_W-1:0] x0_reg, y0_reg, x1_reg, y1_reg;
    logic [31:0]        color_reg;
    logic               mode_reg;
    logic [5:0]         fb_reg;
    logic [MASK_W-1:0]  pend_mask_reg;
    logic               pend_valid_reg;
    logic [COORD_W-1:0] pend_row_reg;
    logic [COORD_W-4:0] pend_chunk_reg;
    logic               last_reg;
    logic               done_reg;

    logic [COORD_W-1:0] cur_col, cur_row;
    logic [COORD_W-4:0] cur_chunk;
    logic               step_last, step_setup, step_advance;
    logic               chunk_break, push1, push2;
    logic [MASK_W-1:0]  pix_mask;
    logic [63:0]        addr_full;
    logic               unused_bits;

    prim_draw_stepper #(.COORD_W(COORD_W)) u_stepper (
        .clk     (clk),
        .rst_n   (rst_n),
        .setup   (step_setup),
        .advance (step_advance),
        .mode    (mode_reg),
        .x0      (x0_reg),
        .y0      (y0_reg),
        .x1      (x1_reg),
        .y1      (y1_reg),
        .col     (cur_col),
        .row     (cur_row),
        .last    (step_last)
    );

    // Pixel p owns the 4 byte-mask bits starting at the MSB end of the chunk mask.
    genvar gi;
    generate
        for (gi = 0; gi < PIX_PER_CHUNK; gi++) begin : g_pix
            assign pix_mask[MASK_W-1-4*gi -: 4] = {4{cur_col[2:0] == 3'(gi)}};
        end
    endgenerate

    assign cur_chunk    = cur_col[COORD_W-1:3];
    assign chunk_break  = pend_valid_reg && ((cur_row != pend_row_reg) ||
                          (cur_chunk != pend_chunk_reg) || (COALESCE == 0));
    assign step_setup   = (state_reg == S_SETUP);
    assign step_advance = (state_reg == S_PLOT) && !chunk_break && !step_last;
    assign push1        = (state_reg == S_SEND1) && !af_full && !wdf_full;
    assign push2        = (state_reg == S_SEND2) && !wdf_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            x0_reg         <= '0;
            y0_reg         <= '0;
            x1_reg         <= '0;
            y1_reg         <= '0;
            color_reg      <= '0;
            mode_reg       <= MODE_LINE;
            fb_reg         <= '0;
            pend_mask_reg  <= '1;
            pend_valid_reg <= 1'b0;
            pend_row_reg   <= '0;
            pend_chunk_reg <= '0;
            last_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (LE_color_valid) color_reg <= LE_color;
                    if (LE_x0_valid)    x0_reg    <= LE_point;
                    if (LE_y0_valid)    y0_reg    <= LE_point;
                    if (LE_x1_valid)    x1_reg    <= LE_point;
                    if (LE_y1_valid)    y1_reg    <= LE_point;
                    if (LE_trigger) begin
                        mode_reg  <= LE_mode;
                        fb_reg    <= LE_frame_base[27:22];
                        last_reg  <= 1'b0;
                        state_reg <= S_SETUP;
                    end
                end
                S_SETUP: state_reg <= S_PLOT;
                S_PLOT: begin
                    // A pixel outside the pending chunk flushes first; the stepper holds.
                    if (chunk_break) begin
                        state_reg <= S_SEND1;
                    end else begin
                        pend_mask_reg  <= pend_mask_reg & ~pix_mask;
                        pend_valid_reg <= 1'b1;
                        pend_row_reg   <= cur_row;
                        pend_chunk_reg <= cur_chunk;
                        if (step_last) begin
                            last_reg  <= 1'b1;
                            state_reg <= S_SEND1;
                        end
                    end
                end
                S_SEND1: if (push1) state_reg <= S_SEND2;
                S_SEND2: begin
                    if (push2) begin
                        pend_mask_reg  <= '1;
                        pend_valid_reg <= 1'b0;
                        if (last_reg) begin
                            state_reg <= S_IDLE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= S_PLOT;
                        end
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign addr_full   = pack_addr(fb_reg, 32'(pend_row_reg), 32'(pend_chunk_reg), COORD_W);
    assign af_addr_din = addr_full[ADDR_W-1:0];
    assign af_wr_en    = push1;
    assign wdf_wr_en   = push1 | push2;
    assign wdf_din     = {4{color_reg}};
    assign wdf_mask_din = (state_reg == S_SEND1) ? pend_mask_reg[MASK_W-1 -: BEAT_BITS] :
                          (state_reg == S_SEND2) ? pend_mask_reg[BEAT_BITS-1:0] : 16'hFFFF;
    assign LE_ready    = (state_reg == S_IDLE);
    assign LE_done     = done_reg;

    assign unused_bits = ^{LE_frame_base[31:28], LE_frame_base[21:0], addr_full};

endmodule
